ms_uart_rx_core: RTL

- Receive-side serial engine of the MS UART. Samples the RX pin at 16x the baud rate and deserialises 8-bit frames, LSB first.
- Checks the start bit, optional parity and the stop bit(s). Pushes each completed byte into the RX FIFO, which feeds RX_DOUT and read_fifo.
- Sits directly upstream of the RX FIFO. Baud divisor (UBRR) and control bits (decoded from UCR by the wrapper) are shared with the TX path.

---
 rtl/ms_uart_rx_core.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ms_uart_rx_core.sv
// ms_uart_rx_core -- receive-side serial engine of the MS UART.
// Oversamples RX at OVS ticks per bit, deserialises DATA_W-bit frames LSB
// first, checks start / optional parity / one or two stop bits and issues a
// one-cycle write strobe toward the RX FIFO together with the error flags.
module ms_uart_rx_core #(
    parameter int DATA_W = 8,
    parameter int OVS    = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              RX,
    input  logic [15:0]       UBRR,
    input  logic              RX_EN,
    input  logic              PAR_EN,
    input  logic              PAR_ODD,
    input  logic              STOP2,
    input  logic              FIFO_FULL,
    input  logic              CLR_ERR,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              RX_WR,
    output logic              FRAME_ERR,
    output logic              PARITY_ERR,
    output logic              OVERRUN,
    output logic              BUSY
);

    localparam int TC_W  = $clog2(OVS);
    localparam int BIT_W = $clog2(DATA_W);

    // Tick-in-bit value at which the bit centre is sampled.
    localparam logic [TC_W-1:0]  TC_MID   = TC_W'(OVS / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    // Synchronizer and edge-detect flops.
    logic              r_rx_meta;
    logic              r_rx_s;
    logic              r_rx_s_d;

    // Baud tick generator.
    logic [15:0]       r_baud_cnt;
    logic [15:0]       r_ubrr_l;
    logic [TC_W-1:0]   r_tc;

    // Frame state.
    state_t            r_state;
    logic              r_busy;
    logic [DATA_W-1:0] r_shreg;
    logic [BIT_W-1:0]  r_bit_idx;
    logic              r_ferr;
    logic              r_perr;

    // Registered outputs.
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_wr;
    logic              r_frame_err;
    logic              r_parity_err;
    logic              r_overrun;

    logic              w_tick;
    logic              w_mid;
    logic              w_start_det;
    logic              w_par_exp;
    logic              w_complete;
    logic              w_ferr_done;

    assign w_tick      = (r_baud_cnt == r_ubrr_l);
    assign w_mid       = w_tick && (r_tc == TC_MID);

    // A falling edge is required, so a held-low line (break) never re-arms
    // the receiver until it has gone high again.
    assign w_start_det = RX_EN && (r_state == S_IDLE) && r_rx_s_d && !r_rx_s;

    // Value the parity bit must carry for the byte now in the shift register.
    assign w_par_exp   = (^r_shreg) ^ PAR_ODD;

    // The frame completes on the mid-sample of its last stop bit.
    assign w_complete  = w_mid && (((r_state == S_STOP1) && !STOP2) ||
                                   (r_state == S_STOP2));

    // Frame error including the stop bit being sampled right now.
    assign w_ferr_done = r_ferr || !r_rx_s;

    // Two-flop synchronizer on the asynchronous RX pin plus one delay flop
    // for falling-edge detection; all idle high so reset looks like a quiet line.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_s_d  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make each flop take the previous
            // stage's old value, which is what builds a real shift chain.
            r_rx_meta <= RX;
            r_rx_s    <= r_rx_meta;
            r_rx_s_d  <= r_rx_s;
        end
    end

    // Free-running baud counter and tick-in-bit counter; both are realigned
    // to the start edge so the mid-bit sample lands in the bit centre.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_baud_cnt <= '0;
            r_ubrr_l   <= '0;
            r_tc       <= '0;
        end else begin
            // Divisor is frozen for the duration of a frame.
            if (r_state == S_IDLE) begin
                r_ubrr_l <= UBRR;
            end

            if (w_start_det) begin
                r_baud_cnt <= '0;
                r_tc       <= '0;
            end else if (w_tick) begin
                r_baud_cnt <= '0;
                r_tc       <= r_tc + TC_W'(1);
            end else begin
                r_baud_cnt <= r_baud_cnt + 16'd1;
            end
        end
    end

    // Receive FSM with registered completion outputs and sticky overrun.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_shreg      <= '0;
            r_bit_idx    <= '0;
            r_ferr       <= 1'b0;
            r_perr       <= 1'b0;
            r_rx_data    <= '0;
            r_rx_wr      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse unless re-asserted below.
            r_rx_wr <= 1'b0;

            // NOTE: the overrun set further down is a later non-blocking
            // assignment to the same flop, so it wins over this clear.
            if (CLR_ERR) begin
                r_overrun <= 1'b0;
            end

            if (!RX_EN) begin
                // Disabling the receiver abandons any frame in flight.
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start_det) begin
                            r_state   <= S_START;
                            r_busy    <= 1'b1;
                            r_ferr    <= 1'b0;
                            r_perr    <= 1'b0;
                            r_bit_idx <= '0;
                        end
                    end

                    S_START: begin
                        if (w_mid) begin
                            if (r_rx_s) begin
                                // Line back high at the centre: a glitch.
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state   <= S_DATA;
                                r_bit_idx <= '0;
                            end
                        end
                    end

                    S_DATA: begin
                        if (w_mid) begin
                            r_shreg <= {r_rx_s, r_shreg[DATA_W-1:1]};
                            if (r_bit_idx == BIT_LAST) begin
                                r_bit_idx <= '0;
                                r_state   <= PAR_EN ? S_PARITY : S_STOP1;
                            end else begin
                                r_bit_idx <= r_bit_idx + BIT_W'(1);
                            end
                        end
                    end

                    S_PARITY: begin
                        if (w_mid) begin
                            if (r_rx_s != w_par_exp) begin
                                r_perr <= 1'b1;
                            end
                            r_state <= S_STOP1;
                        end
                    end

                    S_STOP1: begin
                        if (w_mid) begin
                            if (!r_rx_s) begin
                                r_ferr <= 1'b1;
                            end
                            if (STOP2) begin
                                r_state <= S_STOP2;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end

                    S_STOP2: begin
                        if (w_mid) begin
                            if (!r_rx_s) begin
                                r_ferr <= 1'b1;
                            end
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase

                // Publish the frame; errored frames are still delivered.
                if (w_complete) begin
                    r_rx_data    <= r_shreg;
                    r_frame_err  <= w_ferr_done;
                    r_parity_err <= r_perr && PAR_EN;
                    if (FIFO_FULL) begin
                        r_overrun <= 1'b1;
                    end else begin
                        r_rx_wr <= 1'b1;
                    end
                end
            end
        end
    end

    assign RX_DATA    = r_rx_data;
    assign RX_WR      = r_rx_wr;
    assign FRAME_ERR  = r_frame_err;
    assign PARITY_ERR = r_parity_err;
    assign OVERRUN    = r_overrun;
    assign BUSY       = r_busy;

endmodule
